// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared constants and types for the SRAM bank controller.
//   DATA_WIDTH  : macro word width in bits
//   MASK_WIDTH  : number of byte lanes in a word
//   ADDR_WIDTH  : word address width of one macro
//   sram_req_t  : one word request as seen on the core request port
package sram_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_WIDTH = 9;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [MASK_WIDTH-1:0] wmask;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
// Synchronous response FIFO holding read data on its way back to the core.
// Storage is cleared on reset so the head reads as zero while empty after reset.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail (ignored when full)
//   push_data_i   : data to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   count_o       : number of stored entries
//   valid_o       : FIFO holds at least one entry
//   head_o        : oldest entry
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH  = 4,
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      count_d, count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && (count_q != CNT_W'(RSP_DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Pointers wrap explicitly so depths that are not a power of two work.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // A simultaneous push and pop leaves the count unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl
// Bridges the core data-memory request port to a set of 1RW1R OpenRAM macros.
// The upper address bits pick a bank; that bank's port 0 is driven from
// registers so the macro sees clean control for a whole cycle. Reads come
// back in order through a response FIFO; port 1 of every macro is parked.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_*                 : valid/ready word request (we, addr, wmask, wdata)
//   rsp_*                 : valid/ready read response (rdata)
//   sram_clk0_o .. din0_o : per-bank port-0 controls, packed bank 0 in the LSBs
//   sram_dout0_i          : per-bank port-0 read data, packed the same way
//   sram_clk1_o, csb1_o, addr1_o : port-1 controls, held idle
module sram_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int RSP_DEPTH  = 4,
    localparam int BANK_W     = $clog2(NUM_BANKS),
    localparam int MASK_W     = DATA_WIDTH / 8,
    localparam int REQ_ADDR_W = ADDR_WIDTH + BANK_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [REQ_ADDR_W-1:0]           req_addr_i,
    input  logic [MASK_W-1:0]               req_wmask_i,
    input  logic [DATA_WIDTH-1:0]           req_wdata_i,

    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,

    output logic [NUM_BANKS-1:0]            sram_clk0_o,
    output logic [NUM_BANKS-1:0]            sram_csb0_o,
    output logic [NUM_BANKS-1:0]            sram_web0_o,
    output logic [NUM_BANKS*MASK_W-1:0]     sram_wmask0_o,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] sram_din0_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout0_i,

    output logic [NUM_BANKS-1:0]            sram_clk1_o,
    output logic [NUM_BANKS-1:0]            sram_csb1_o,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] sram_addr1_o
);

    // A single-bank build still needs a one-bit select to index arrays.
    localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W  = $clog2(RSP_DEPTH + 3);

    logic                  accept;
    logic [BSEL_W-1:0]     bank_sel;
    logic [ADDR_WIDTH-1:0] word_addr;

    logic [NUM_BANKS-1:0]  csb_d, csb_q;
    logic [NUM_BANKS-1:0]  web_d, web_q;
    logic [ADDR_WIDTH-1:0] addr_d  [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] din_d   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] din_q   [NUM_BANKS];
    logic [MASK_W-1:0]     wmask_d [NUM_BANKS];
    logic [MASK_W-1:0]     wmask_q [NUM_BANKS];

    logic                  s1_vld_d, s1_vld_q;
    logic [BSEL_W-1:0]     s1_bank_d, s1_bank_q;
    logic                  s2_vld_d, s2_vld_q;
    logic [BSEL_W-1:0]     s2_bank_d, s2_bank_q;

    logic [DATA_WIDTH-1:0] dout_arr [NUM_BANKS];
    logic [DATA_WIDTH-1:0] push_data;
    logic                  rsp_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occupancy;

    generate
        if (BANK_W > 0) begin : g_bank_dec
            assign bank_sel = req_addr_i[REQ_ADDR_W-1 -: BANK_W];
        end else begin : g_single_bank
            assign bank_sel = '0;
        end
    endgenerate

    assign word_addr = req_addr_i[ADDR_WIDTH-1:0];

    // Occupancy counts reads still in the pipe so a FIFO slot is always
    // reserved for them; ready therefore never looks at rsp_ready_i or req_we_i.
    assign occupancy   = OCC_W'(fifo_count) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
    assign req_ready_o = (occupancy < OCC_W'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    // Only the addressed bank gets new addr/din/wmask; the others keep theirs
    // so their data pins do not toggle. Chip selects drop back every idle cycle.
    always_comb begin
        csb_d   = '1;
        web_d   = '1;
        addr_d  = addr_q;
        din_d   = din_q;
        wmask_d = wmask_q;
        if (accept) begin
            csb_d[bank_sel]   = 1'b0;
            web_d[bank_sel]   = !req_we_i;
            addr_d[bank_sel]  = word_addr;
            din_d[bank_sel]   = req_wdata_i;
            wmask_d[bank_sel] = req_wmask_i;
        end
    end

    // Read tracking: stage 1 is the cycle the macro sees the command, stage 2
    // is the cycle its dout is valid and gets pushed into the FIFO.
    always_comb begin
        s1_vld_d  = accept && !req_we_i;
        s1_bank_d = (accept && !req_we_i) ? bank_sel : s1_bank_q;
        s2_vld_d  = s1_vld_q;
        s2_bank_d = s1_bank_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csb_q     <= '1;
            web_q     <= '1;
            addr_q    <= '{default: '0};
            din_q     <= '{default: '0};
            wmask_q   <= '{default: '0};
            s1_vld_q  <= 1'b0;
            s1_bank_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_bank_q <= '0;
        end else begin
            csb_q     <= csb_d;
            web_q     <= web_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wmask_q   <= wmask_d;
            s1_vld_q  <= s1_vld_d;
            s1_bank_q <= s1_bank_d;
            s2_vld_q  <= s2_vld_d;
            s2_bank_q <= s2_bank_d;
        end
    end

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank_io
            assign sram_addr0_o[b*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[b];
            assign sram_din0_o[b*DATA_WIDTH +: DATA_WIDTH]  = din_q[b];
            assign sram_wmask0_o[b*MASK_W +: MASK_W]        = wmask_q[b];
            assign dout_arr[b] = sram_dout0_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign sram_clk0_o  = {NUM_BANKS{clk_i}};
    assign sram_csb0_o  = csb_q;
    assign sram_web0_o  = web_q;

    assign sram_clk1_o  = {NUM_BANKS{clk_i}};
    assign sram_csb1_o  = '1;
    assign sram_addr1_o = '0;

    assign push_data = dout_arr[s2_bank_q];
    assign rsp_pop   = rsp_valid_o && rsp_ready_i;

    sram_rsp_fifo #(
        .RSP_DEPTH  (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (s2_vld_q),
        .push_data_i (push_data),
        .pop_i       (rsp_pop),
        .count_o     (fifo_count),
        .valid_o     (rsp_valid_o),
        .head_o      (rsp_rdata_o)
    );

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl
// Self-checking bench for sram_bank_ctrl. A behavioural macro model answers
// port 0; a shadow memory plus an expected-response queue predicts read data,
// ready (outstanding reads < depth) and response latency (two cycles).
module tb_sram_bank_ctrl;
    import sram_ctrl_pkg::*;

    localparam int NB    = 2;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 4;
    localparam int RAW   = 10;

    logic              clk;
    logic              rst_ni;
    logic              req_valid, req_ready, req_we;
    logic [RAW-1:0]    req_addr;
    logic [MW-1:0]     req_wmask;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic [NB-1:0]     sram_clk0, sram_csb0, sram_web0;
    logic [NB*MW-1:0]  sram_wmask0;
    logic [NB*AW-1:0]  sram_addr0;
    logic [NB*DW-1:0]  sram_din0;
    logic [NB*DW-1:0]  sram_dout0;
    logic [NB-1:0]     sram_clk1, sram_csb1;
    logic [NB*AW-1:0]  sram_addr1;

    int errors = 0;
    int checks = 0;

    sram_bank_ctrl #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .sram_clk0_o(sram_clk0), .sram_csb0_o(sram_csb0), .sram_web0_o(sram_web0),
        .sram_wmask0_o(sram_wmask0), .sram_addr0_o(sram_addr0), .sram_din0_o(sram_din0),
        .sram_dout0_i(sram_dout0),
        .sram_clk1_o(sram_clk1), .sram_csb1_o(sram_csb1), .sram_addr1_o(sram_addr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [MW-1:0] m);
        merge_bytes = old_w;
        for (int i = 0; i < MW; i++) begin
            if (m[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    // Behavioural OpenRAM port 0: samples control at the rising edge,
    // dout becomes valid after that edge and holds until the next read.
    logic [DW-1:0] macro_mem  [NB][1<<AW];
    logic [DW-1:0] macro_dout [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb0[b]) begin
                if (!sram_web0[b])
                    macro_mem[b][sram_addr0[b*AW +: AW]] <= merge_bytes(
                        macro_mem[b][sram_addr0[b*AW +: AW]],
                        sram_din0[b*DW +: DW], sram_wmask0[b*MW +: MW]);
                else
                    macro_dout[b] <= macro_mem[b][sram_addr0[b*AW +: AW]];
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < NB; gb++) begin : g_dout
            assign sram_dout0[gb*DW +: DW] = macro_dout[gb];
        end
    endgenerate

    // Reference model state, written only from the main initial process.
    logic [DW-1:0] shadow [1<<RAW];
    logic [DW-1:0] exp_q [$];
    int            acc_cyc_q [$];
    int            cyc = 0;
    bit            accepted, popped, spurious;
    logic [DW-1:0] last_act, last_exp;

    task automatic set_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
    endtask

    task automatic drive_req(input bit we, input logic [RAW-1:0] addr,
                             input logic [MW-1:0] mask, input logic [DW-1:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = mask;
        req_wdata = data;
    endtask

    // Advance one clock. Handshakes are observed at the falling edge, where
    // inputs and DUT outputs are stable, and applied to the model.
    task automatic step();
        @(negedge clk);
        accepted = 0;
        popped   = 0;
        spurious = 0;
        if (rst_ni) begin
            if (req_valid && req_ready) begin
                accepted = 1;
                if (req_we) begin
                    shadow[req_addr] = merge_bytes(shadow[req_addr], req_wdata, req_wmask);
                end else begin
                    exp_q.push_back(shadow[req_addr]);
                    acc_cyc_q.push_back(cyc + 1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                popped   = 1;
                last_act = rsp_rdata;
                if (exp_q.size() == 0) begin
                    spurious = 1;
                end else begin
                    last_exp = exp_q.pop_front();
                    void'(acc_cyc_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rsp_ready = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sram_csb0 !== 2'b11) begin errors++; $display("[TB] FAIL reset_csb0: got %b want 11", sram_csb0); end
        checks++; if (sram_web0 !== 2'b11) begin errors++; $display("[TB] FAIL reset_web0: got %b want 11", sram_web0); end
        checks++; if (sram_addr0 !== '0) begin errors++; $display("[TB] FAIL reset_addr0: got %h want 0", sram_addr0); end
        checks++; if (sram_din0 !== '0) begin errors++; $display("[TB] FAIL reset_din0: got %h want 0", sram_din0); end
        checks++; if (sram_wmask0 !== '0) begin errors++; $display("[TB] FAIL reset_wmask0: got %h want 0", sram_wmask0); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (sram_csb1 !== 2'b11 || sram_addr1 !== '0) begin errors++; $display("[TB] FAIL reset_port1: csb1=%b addr1=%h want 11/0", sram_csb1, sram_addr1); end
        checks++; if (sram_clk0 !== 2'b11 || sram_clk1 !== 2'b11) begin errors++; $display("[TB] FAIL reset_clk_fwd: clk0=%b clk1=%b want 11/11", sram_clk0, sram_clk1); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        drive_req(1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
        step();
        checks++; if (sram_csb0 !== 2'b10 || sram_web0 !== 2'b10) begin errors++; $display("[TB] FAIL wr_ctrl: csb0=%b web0=%b want 10/10", sram_csb0, sram_web0); end
        checks++; if (sram_addr0[AW-1:0] !== 9'h005 || sram_din0[DW-1:0] !== 32'hDEADBEEF || sram_wmask0[MW-1:0] !== 4'hF) begin
            errors++; $display("[TB] FAIL wr_data: addr=%h din=%h mask=%h want 005/deadbeef/f", sram_addr0[AW-1:0], sram_din0[DW-1:0], sram_wmask0[MW-1:0]);
        end
        drive_req(1'b0, 10'h005, 4'h0, 32'h0);
        step();
        checks++; if (sram_csb0 !== 2'b10 || sram_web0 !== 2'b11) begin errors++; $display("[TB] FAIL rd_ctrl: csb0=%b web0=%b want 10/11", sram_csb0, sram_web0); end
        set_idle();
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_latency_early: rsp_valid=%b want 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL raw_data: valid=%b rdata=%h want 1/deadbeef", rsp_valid, rsp_rdata);
        end
        step();
        checks++; if (!popped || spurious || last_act !== last_exp) begin
            errors++; $display("[TB] FAIL raw_pop: popped=%0d rdata=%h want %h", popped, last_act, last_exp);
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_empty: rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_byte_mask();
        bit got = 0;
        rsp_ready = 1'b1;
        drive_req(1'b1, 10'h201, 4'hF, 32'hFFFFFFFF);
        step();
        checks++; if (sram_csb0[0] !== 1'b1) begin errors++; $display("[TB] FAIL mask_bank0_idle_w1: csb0[0]=%b want 1", sram_csb0[0]); end
        drive_req(1'b1, 10'h201, 4'h5, 32'h00000000);
        step();
        checks++; if (sram_csb0 !== 2'b01 || sram_wmask0[2*MW-1:MW] !== 4'h5) begin
            errors++; $display("[TB] FAIL mask_w2_ctrl: csb0=%b wmask1=%h want 01/5", sram_csb0, sram_wmask0[2*MW-1:MW]);
        end
        drive_req(1'b0, 10'h201, 4'h0, 32'h0);
        step();
        checks++; if (sram_csb0[0] !== 1'b1) begin errors++; $display("[TB] FAIL mask_bank0_idle_rd: csb0[0]=%b want 1", sram_csb0[0]); end
        set_idle();
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (sram_csb0[0] !== 1'b1) begin errors++; $display("[TB] FAIL mask_bank0_idle: csb0[0]=%b want 1", sram_csb0[0]); end
            if (popped) begin
                got = 1;
                checks++; if (spurious || last_act !== 32'hFF00FF00 || last_exp !== 32'hFF00FF00) begin
                    errors++; $display("[TB] FAIL mask_data: rdata=%h model=%h want ff00ff00", last_act, last_exp);
                end
            end
        end
        checks++; if (!got) begin errors++; $display("[TB] FAIL mask_timeout: no response, want one"); end
    endtask

    task automatic test_prefill();
        // Defines every word the later tests read: 0x000-0x01F and 0x200-0x21F.
        rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            drive_req(1'b1, (i < 32) ? RAW'(i) : RAW'(10'h200 + i - 32), 4'hF, $urandom);
            step();
            checks++; if (!accepted) begin errors++; $display("[TB] FAIL prefill_accept: write %0d not accepted", i); end
        end
        set_idle();
        step();
    endtask

    task automatic test_streaming();
        int n_rsp = 0;
        int first_pop = -1;
        int last_pop = -1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i < 16) begin
                drive_req(1'b0, RAW'(i), 4'h0, 32'h0);
                checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready: cycle %0d ready=%b want 1", i, req_ready); end
            end else begin
                set_idle();
            end
            step();
            if (popped) begin
                n_rsp++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                checks++; if (spurious || last_act !== last_exp) begin
                    errors++; $display("[TB] FAIL stream_data: rsp %0d rdata=%h want %h", n_rsp, last_act, last_exp);
                end
            end
        end
        checks++; if (n_rsp != 16) begin errors++; $display("[TB] FAIL stream_count: got %0d responses want 16", n_rsp); end
        checks++; if (first_pop != 3 || last_pop - first_pop != 15) begin
            errors++; $display("[TB] FAIL stream_rate: first pop %0d last pop %0d want 3/18", first_pop, last_pop);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_pop = 0;
        bit held = 0;
        logic [DW-1:0] held_data = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_req(1'b0, RAW'($urandom_range(0, 31)), 4'h0, 32'h0);
            step();
            if (accepted) n_acc++;
            if (rsp_valid && !held) begin
                held = 1;
                held_data = rsp_rdata;
            end else if (held) begin
                checks++; if (rsp_rdata !== held_data || rsp_valid !== 1'b1) begin
                    errors++; $display("[TB] FAIL bp_hold: rdata=%h valid=%b want %h/1", rsp_rdata, rsp_valid, held_data);
                end
            end
        end
        checks++; if (n_acc != DEPTH) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want %0d", n_acc, DEPTH); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: ready=%b want 0", req_ready); end
        set_idle();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (!popped || spurious || last_act !== last_exp) begin
            errors++; $display("[TB] FAIL bp_first_pop: popped=%0d rdata=%h want %h", popped, last_act, last_exp);
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_return: ready=%b want 1", req_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (popped) begin
                n_pop++;
                checks++; if (spurious || last_act !== last_exp) begin
                    errors++; $display("[TB] FAIL bp_drain: rdata=%h want %h", last_act, last_exp);
                end
            end
        end
        checks++; if (n_pop != DEPTH - 1) begin errors++; $display("[TB] FAIL bp_drain_count: got %0d want %0d", n_pop, DEPTH - 1); end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] a_data;
        logic [NB-1:0] exp_csb;
        int n_pop = 0;
        a_data = $urandom;
        rsp_ready = 1'b1;
        drive_req(1'b1, 10'h010, 4'hF, a_data);
        step();
        drive_req(1'b1, 10'h210, 4'hF, ~a_data);
        step();
        for (int i = 0; i < 16; i++) begin
            if (i < 8) drive_req(1'b0, (i % 2 == 0) ? 10'h010 : 10'h210, 4'h0, 32'h0);
            else set_idle();
            step();
            exp_csb = (i < 8) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b11;
            checks++; if (sram_csb0 !== exp_csb) begin
                errors++; $display("[TB] FAIL ilv_csb: cycle %0d csb0=%b want %b", i, sram_csb0, exp_csb);
            end
            if (popped) begin
                n_pop++;
                checks++; if (spurious || last_act !== last_exp) begin
                    errors++; $display("[TB] FAIL ilv_data: rsp %0d rdata=%h want %h", n_pop, last_act, last_exp);
                end
            end
        end
        checks++; if (n_pop != 8) begin errors++; $display("[TB] FAIL ilv_count: got %0d want 8", n_pop); end
    endtask

    task automatic test_random();
        sram_req_t r;
        logic      bank;
        bit        exp_valid;
        for (int i = 0; i < 420; i++) begin
            r.we    = ($urandom_range(0, 2) == 0);
            r.addr  = AW'($urandom_range(0, 31));
            r.wmask = MASK_WIDTH'($urandom);
            r.wdata = $urandom;
            bank    = 1'($urandom);
            if (i < 400 && $urandom_range(0, 3) != 0) drive_req(r.we, {bank, r.addr}, r.wmask, r.wdata);
            else set_idle();
            rsp_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
            step();
            if (popped) begin
                checks++; if (spurious || last_act !== last_exp) begin
                    errors++; $display("[TB] FAIL rand_data: step %0d rdata=%h want %h", i, last_act, last_exp);
                end
            end
            checks++; if (req_ready !== (exp_q.size() < DEPTH)) begin
                errors++; $display("[TB] FAIL rand_ready: step %0d ready=%b outstanding=%0d", i, req_ready, exp_q.size());
            end
            exp_valid = (acc_cyc_q.size() > 0) && (cyc >= acc_cyc_q[0] + 2);
            checks++; if (rsp_valid !== exp_valid) begin
                errors++; $display("[TB] FAIL rand_valid: step %0d rsp_valid=%b want %b", i, rsp_valid, exp_valid);
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_drain: %0d responses missing, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_read();
        rsp_ready = 1'b1;
        drive_req(1'b0, 10'h003, 4'h0, 32'h0);
        step();
        set_idle();
        checks++; if (sram_csb0 !== 2'b10) begin errors++; $display("[TB] FAIL rmid_issue: csb0=%b want 10", sram_csb0); end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (sram_csb0 !== 2'b11 || sram_web0 !== 2'b11) begin
            errors++; $display("[TB] FAIL rmid_async_ctrl: csb0=%b web0=%b want 11/11", sram_csb0, sram_web0);
        end
        checks++; if (sram_addr0 !== '0 || rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rmid_async_clear: addr0=%h rsp_valid=%b want 0/0", sram_addr0, rsp_valid);
        end
        exp_q.delete();
        acc_cyc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL rmid_after: cycle %0d rsp_valid=%b ready=%b want 0/1", i, rsp_valid, req_ready);
            end
            step();
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << RAW); a++) shadow[a] = '0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_prefill();
        test_streaming();
        test_backpressure();
        test_interleave();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
